sram_controller: RTL
====================

# sram_controller

Multi-cycle controller between the EXE stage and the MEM stage register, replacing the single-cycle data memory with an external 16-bit asynchronous SRAM. It accepts one 32-bit load or store per request, performs it as two 16-bit SRAM accesses with a programmable wait count, and holds `ready` low while busy. The top level derives the pipeline `freeze` from `~ready`.

## Interface
- `WAIT_CYCLES`, default 3: cycles per 16-bit SRAM access; legal range 1..15.
- `BASE_ADDR`, default 1024: first byte address of data memory.
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `rd_en` in 1: load request from EXE.
- `wr_en` in 1: store request from EXE.
- `address` in 32: byte address, which is the ALU result.
- `writeData` in 32: store data, which is `val_Rm`.
- `readData` out 32: registered load result.
- `ready` out 1: request complete or idle. Low means the pipeline freezes.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_WE_N` out 1: SRAM write strobe, active low.

## Operation
- States:
  - IDLE, LOW, HIGH, DONE.
  - A 4-bit wait counter `cnt` runs in LOW and HIGH.
- IDLE:
  - With `rd_en|wr_en`: latch the op, word index and `writeData`, clear `cnt`, and go to LOW.
  - Otherwise stay in IDLE.
- LOW and HIGH:
  - Increment `cnt` each cycle.
  - When `cnt==WAIT_CYCLES-1`, clear `cnt` and advance (LOW to HIGH, HIGH to DONE).
- DONE: go to IDLE unconditionally.
- Address map:
  - word index = `(address - BASE_ADDR) >> 2`, truncated to 17 bits. Out-of-range addresses wrap and are not flagged.
  - `SRAM_ADDR = {index, 1'b0}` in LOW and `{index, 1'b1}` in HIGH; 0 in IDLE and DONE.
- Store:
  - `SRAM_WE_N` is 0 for every LOW and HIGH cycle.
  - `SRAM_DQ` carries `writeData[15:0]` in LOW and `writeData[31:16]` in HIGH.
  - `SRAM_DQ` is Z in every other case.
- Load:
  - `SRAM_WE_N` stays 1 and `SRAM_DQ` is Z.
  - The controller captures `SRAM_DQ` into `readData[15:0]` on the last LOW cycle and into `readData[31:16]` on the last HIGH cycle.
  - `readData` keeps its value until the next load completes. Stores never modify it.
- `ready`:
  - Combinational: `(state==IDLE & ~(rd_en|wr_en)) | state==DONE`.
  - `ready` therefore drops in the same cycle a request appears, so the pipeline freezes immediately.
- If `rd_en` and `wr_en` are both set, the controller performs a store and ignores the read.
- The requester holds `address`, `writeData` and the enables stable until `ready` is high. The controller latches them anyway.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `readData` 0, `SRAM_ADDR` 0, `SRAM_WE_N` 1, `SRAM_DQ` Z.
  - `ready` is 1 if there is no request.
- Request first seen in cycle 0 (IDLE):
  - LOW covers cycles 1..W.
  - HIGH covers cycles W+1..2W.
  - DONE is cycle 2W+1, with `ready`=1 and `readData` valid.
- Total busy cycles: 2W+1. With default W=3, `ready` is low in cycles 0..6 and high in cycle 7.
- At the DONE→IDLE edge the pipeline advances. A request present in the following cycle is a new one and is accepted immediately, with no bubble cycle.
- Reset asserted mid-access aborts the access:
  - `SRAM_WE_N` returns to 1 asynchronously and `SRAM_DQ` goes to Z.
  - The SRAM contents of that word are undefined.

## Configuration
- `SRAM_READ_REUSE_EN`
  - Defined:
    - Keep a register of the last completed load's word index plus a valid bit. Reset clears the valid bit, and so does any store to any address.
    - A load in IDLE whose index matches with the valid bit set is a hit: `ready` stays 1, the state stays IDLE, and `readData` is unchanged (it already holds the word). There is zero stall.
  - Undefined: every load takes 2W+1 cycles.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum (IDLE, LOW, HIGH, DONE)
  - `BASE_ADDR` default 1024
  - `SRAM_AW` = 18
  - `SRAM_DW` = 16
- No sub-module. The counter, FSM, tri-state driver and reuse register are all inline.

## Test plan
- Store 0xDEADBEEF to 1024, then load from 1024 (W=3):
  - `ready` is low for 7 cycles each.
  - `SRAM_ADDR` is 0 then 1.
  - DQ carries 0xBEEF then 0xDEAD.
  - `readData`=0xDEADBEEF in DONE.
- Back-to-back stores to 1028 and 1032 with requests held continuously:
  - The second access starts the cycle after DONE.
  - `SRAM_ADDR` sequence is 2, 3, 4, 5.
- Load with `rd_en` and `wr_en` both high at 1040, data 0x12345678: a store occurs and `readData` is unchanged.
- Assert `rst` during the HIGH phase of a store:
  - `SRAM_WE_N`=1 and DQ=Z in the same cycle.
  - `ready`=1 next cycle with no request.
- Address 1024+4*131072 (0x80400): wraps to `SRAM_ADDR` 0 and 1.
- With `SRAM_READ_REUSE_EN`:
  - A repeat load of 1024 has `ready` high with no stall and `readData` held.
  - After an intervening store to 2000, the same load stalls 7 cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the external 16-bit SRAM data-memory controller.
package sram_pkg;
    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam logic [31:0] BASE_ADDR = 32'd1024;
    localparam int unsigned SRAM_AW   = 18;
    localparam int unsigned SRAM_DW   = 16;
endpackage

// File: rtl/sram_controller.sv
// 32-bit load/store over a 16-bit asynchronous SRAM as two timed halfword accesses.
// Optional feature: `define SRAM_READ_REUSE_EN to skip repeat loads of the last word read.
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = sram_pkg::BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [31:0]          address,
    input  logic [31:0]          writeData,
    output logic [31:0]          readData,
    output logic                 ready,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_WE_N
);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_is_wr;
    logic [16:0]         r_idx;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;

    logic                w_req;
    logic [16:0]         w_idx;
    logic                w_last;
    logic                w_hit;
    logic                w_start;
    logic                w_access;
    logic                w_drive;

    assign w_req   = rd_en | wr_en;
    // Out-of-range addresses simply wrap into the 17-bit word index.
    assign w_idx   = 17'((address - BASE_ADDR) >> 2);
    assign w_last  = (r_cnt == 4'(WAIT_CYCLES - 1));
    assign w_start = (r_state == IDLE) & w_req & ~w_hit;

`ifdef SRAM_READ_REUSE_EN
    logic                r_reuse_vld;
    logic [16:0]         r_reuse_idx;

    assign w_hit = rd_en & ~wr_en & r_reuse_vld & (w_idx == r_reuse_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reuse_vld <= 1'b0;
            r_reuse_idx <= '0;
        end else if ((r_state == IDLE) && wr_en) begin
            r_reuse_vld <= 1'b0;
        end else if ((r_state == HIGH) && w_last && !r_is_wr) begin
            r_reuse_vld <= 1'b1;
            r_reuse_idx <= r_idx;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = LOW;
            LOW:     if (w_last)  w_next = HIGH;
            HIGH:    if (w_last)  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_is_wr <= wr_en;
                        r_idx   <= w_idx;
                        r_wdata <= writeData;
                        r_cnt   <= '0;
                    end
                end
                LOW, HIGH: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!r_is_wr) begin
                            if (r_state == LOW) r_rdata[15:0]  <= SRAM_DQ;
                            else                r_rdata[31:16] <= SRAM_DQ;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobe and bus enable decode straight from the state register so reset releases them at once.
    assign w_access  = (r_state == LOW) | (r_state == HIGH);
    assign w_drive   = w_access & r_is_wr;
    assign SRAM_ADDR = w_access ? {r_idx, (r_state == HIGH)} : '0;
    assign SRAM_WE_N = ~w_drive;
    assign SRAM_DQ   = w_drive ? ((r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0]) : 'z;

    assign readData  = r_rdata;
    assign ready     = ((r_state == IDLE) & ~(w_req & ~w_hit)) | (r_state == DONE);

endmodule
